// File: rtl/hdmi_i2c_target.sv
// hdmi_i2c_target: I2C target emulating an HDMI transmitter 256x8 register map with write strobes.
// Optional macro I2C_GLITCH_FILTER_EN adds a 3-sample stable filter on synchronised SCL/SDA.
module hdmi_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] mon_addr,
    output logic [7:0] mon_data
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_s, sda_s, scl_prev_q, sda_prev_q;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]             cnt_q;
    logic [7:0]             sh_q, ptr_q, wr_addr_q, wr_data_q, byte_d, rd_d;
    logic                   oe_q, wr_strobe_q, busy_q, sub_seen_q, wr_pend_q;
    logic [7:0]             mem_q [256];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_flt_q, sda_flt_q;
    logic [2:0] scl_win, sda_win;

    assign scl_win = {scl_hist_q, scl_sync_q[SYNC_STAGES-1]};
    assign sda_win = {sda_hist_q, sda_sync_q[SYNC_STAGES-1]};

    // Filtered level follows only once the last three samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= scl_win[1:0];
            sda_hist_q <= sda_win[1:0];
            scl_flt_q  <= (&scl_win) ? 1'b1 : (~|scl_win) ? 1'b0 : scl_flt_q;
            sda_flt_q  <= (&sda_win) ? 1'b1 : (~|sda_win) ? 1'b0 : sda_flt_q;
        end
    end

    assign scl_s = scl_flt_q;
    assign sda_s = sda_flt_q;
`else
    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_d    = {sh_q[6:0], sda_s};
    assign rd_d      = mem_q[ptr_q];

    // ACK slots use cnt_q as a phase marker: 0 before the 8th fall, 1 while driving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            ptr_q       <= '0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            sub_seen_q  <= 1'b0;
            wr_pend_q   <= 1'b0;
            for (int i = 0; i < 256; i++) mem_q[i] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            wr_pend_q   <= 1'b0;
            if (wr_pend_q) begin
                mem_q[ptr_q] <= sh_q;
                wr_strobe_q  <= 1'b1;
                wr_addr_q    <= ptr_q;
                wr_data_q    <= sh_q;
                ptr_q        <= ptr_q + 8'd1;
            end
            if (start_det) begin
                state_q <= ADDR;
                cnt_q   <= '0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b1;
            end else if (stop_det) begin
                state_q    <= IDLE;
                oe_q       <= 1'b0;
                busy_q     <= 1'b0;
                sub_seen_q <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, SUB, WDATA: if (scl_rise) begin
                        sh_q  <= byte_d;
                        cnt_q <= cnt_q + 3'd1;
                        if (&cnt_q) begin
                            if (state_q == ADDR)
                                state_q <= (byte_d[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                            else if (state_q == SUB) begin
                                ptr_q      <= byte_d;
                                sub_seen_q <= 1'b1;
                                state_q    <= SUB_ACK;
                            end else begin
                                wr_pend_q <= 1'b1;
                                state_q   <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
                        oe_q  <= (cnt_q == 3'd0);
                        cnt_q <= (cnt_q == 3'd0) ? 3'd1 : 3'd0;
                        if (cnt_q != 3'd0) begin
                            if (state_q == ADDR_ACK && sh_q[0]) begin
                                state_q <= RDATA;
                                sh_q    <= {rd_d[6:0], 1'b0};
                                oe_q    <= ~rd_d[7];
                                ptr_q   <= ptr_q + 8'd1;
                            end else
                                state_q <= (state_q == ADDR_ACK && !sub_seen_q) ? SUB : WDATA;
                        end
                    end
                    RDATA: if (scl_rise) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (&cnt_q) state_q <= RACK;
                    end else if (scl_fall) begin
                        oe_q <= ~sh_q[7];
                        sh_q <= {sh_q[6:0], 1'b0};
                    end
                    RACK: if (scl_fall) begin
                        if (cnt_q == 3'd0) oe_q <= 1'b0;
                        else begin
                            state_q <= RDATA;
                            cnt_q   <= '0;
                            sh_q    <= {rd_d[6:0], 1'b0};
                            oe_q    <= ~rd_d[7];
                            ptr_q   <= ptr_q + 8'd1;
                        end
                    end else if (scl_rise) begin
                        if (sda_s) state_q <= IGNORE;
                        else cnt_q <= 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe    = oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign mon_data  = mem_q[mon_addr];
endmodule

// File: tb/tb_hdmi_i2c_target.sv
// tb_hdmi_i2c_target: directed I2C master transactions against hdmi_i2c_target.
// Glitch expectations depend on I2C_GLITCH_FILTER_EN.
module tb_hdmi_i2c_target;
    localparam int Q = 8;
`ifdef I2C_GLITCH_FILTER_EN
    localparam logic [7:0] GL_DATA = 8'hA5;
    localparam logic       GL_ACK  = 1'b1;
`else
    localparam logic [7:0] GL_DATA = 8'hD2;
    localparam logic       GL_ACK  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in, sda_oe, wr_strobe, busy;
    logic [7:0] wr_addr, wr_data, mon_addr, mon_data;
    int         n_chk = 0;
    int         n_err = 0;
    logic [15:0] sq[$];
    logic       oe_seen = 1'b0;

    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    hdmi_i2c_target dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_m),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .mon_addr (mon_addr),
        .mon_data (mon_data)
    );

    always @(negedge clk) begin
        if (wr_strobe) sq.push_back({wr_addr, wr_data});
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_bit(input logic b, input logic gl, output logic r);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        r = sda_in;
        if (gl) begin
            scl_m = 1'b0;
            tick(1);
            scl_m = 1'b1;
            tick(Q - 1);
        end else tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(2 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input int gl, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], gl == i, r);
        i2c_bit(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, 1'b0, r);
            d[i] = r;
        end
        i2c_bit(~mack, 1'b0, r);
    endtask

    task automatic reg_is(input string tag, input logic [7:0] a, input logic [7:0] exp);
        mon_addr = a;
        tick(1);
        chk(tag, {8'h00, mon_data}, {8'h00, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, r;
        logic [7:0] d;
        int         s0;
        logic [7:0] a72;
        mon_addr = 8'h00;
        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_oe", sda_oe, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        reg_is("rst_reg98", 8'h98, 8'h00);
        rst_n = 1'b1;
        tick(4);

        s0 = sq.size();
        i2c_start;
        chk("burst_busy", busy, 1);
        wr_byte(8'h72, -1, ack); chk("burst_ack_a", ack, 1);
        wr_byte(8'h98, -1, ack); chk("burst_ack_s", ack, 1);
        wr_byte(8'h03, -1, ack); chk("burst_ack_d0", ack, 1);
        wr_byte(8'hE0, -1, ack); chk("burst_ack_d1", ack, 1);
        i2c_stop;
        chk("burst_idle", busy, 0);
        reg_is("burst_reg98", 8'h98, 8'h03);
        reg_is("burst_reg99", 8'h99, 8'hE0);
        chk("burst_nstb", 16'(sq.size() - s0), 2);
        chk("burst_stb0", (sq.size() > s0) ? sq[s0] : 16'hFFFF, 16'h9803);
        chk("burst_stb1", (sq.size() > s0 + 1) ? sq[s0 + 1] : 16'hFFFF, 16'h99E0);

        s0 = sq.size();
        i2c_start;
        wr_byte(8'h72, -1, ack); chk("rd_ack_a", ack, 1);
        wr_byte(8'h98, -1, ack); chk("rd_ack_s", ack, 1);
        i2c_start;
        wr_byte(8'h73, -1, ack); chk("rd_ack_r", ack, 1);
        rd_byte(1'b1, d); chk("rd_byte0", {8'h00, d}, 16'h0003);
        rd_byte(1'b0, d); chk("rd_byte1", {8'h00, d}, 16'h00E0);
        chk("rd_release", sda_oe, 0);
        i2c_stop;
        chk("rd_nstb", 16'(sq.size() - s0), 0);

        s0 = sq.size();
        oe_seen = 1'b0;
        i2c_start;
        wr_byte(8'h74, -1, ack); chk("mis_nack_a", ack, 0);
        wr_byte(8'h55, -1, ack); chk("mis_nack_d", ack, 0);
        i2c_stop;
        chk("mis_oe", oe_seen, 0);
        chk("mis_nstb", 16'(sq.size() - s0), 0);
        reg_is("mis_reg98", 8'h98, 8'h03);

        s0 = sq.size();
        i2c_start;
        wr_byte(8'h72, -1, ack); chk("wrap_ack_a", ack, 1);
        wr_byte(8'hFF, -1, ack);
        wr_byte(8'h11, -1, ack);
        wr_byte(8'h22, -1, ack); chk("wrap_ack_d1", ack, 1);
        i2c_stop;
        reg_is("wrap_regff", 8'hFF, 8'h11);
        reg_is("wrap_reg00", 8'h00, 8'h22);
        chk("wrap_nstb", 16'(sq.size() - s0), 2);
        chk("wrap_stb0", (sq.size() > s0) ? sq[s0] : 16'hFFFF, 16'hFF11);
        chk("wrap_stb1", (sq.size() > s0 + 1) ? sq[s0 + 1] : 16'hFFFF, 16'h0022);

        s0 = sq.size();
        i2c_start;
        wr_byte(8'h72, -1, ack);
        wr_byte(8'h10, -1, ack); chk("abort_ack_s", ack, 1);
        for (int i = 0; i < 4; i++) i2c_bit(i[0] ? 1'b0 : 1'b1, 1'b0, r);
        i2c_stop;
        reg_is("abort_reg10", 8'h10, 8'h00);
        chk("abort_nstb", 16'(sq.size() - s0), 0);

        s0 = sq.size();
        i2c_start;
        wr_byte(8'h72, -1, ack);
        wr_byte(8'h40, -1, ack);
        wr_byte(8'hA5, 7, ack); chk("glitch_ack", ack, GL_ACK);
        i2c_stop;
        reg_is("glitch_reg40", 8'h40, GL_DATA);
        chk("glitch_stb", (sq.size() > s0) ? sq[s0] : 16'hFFFF, {8'h40, GL_DATA});

        i2c_start;
        a72 = 8'h72;
        for (int i = 7; i >= 0; i--) i2c_bit(a72[i], 1'b0, r);
        for (int i = 0; i < 20 && !sda_oe; i++) tick(1);
        chk("rst_pre_oe", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_oe", sda_oe, 0);
        chk("rst_async_busy", busy, 0);
        tick(1);
        reg_is("rst_reg98b", 8'h98, 8'h00);
        reg_is("rst_regff", 8'hFF, 8'h00);
        reg_is("rst_reg00", 8'h00, 8'h00);
        reg_is("rst_reg40", 8'h40, 8'h00);
        rst_n = 1'b1;
        tick(2);
        i2c_stop;
        chk("rst_after_oe", sda_oe, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
